// File: rtl/mem_responder.sv
// Byte-serial memory responder: services 1/4/8-byte CPU reads and writes as
// little-endian single-byte accesses to a byte-wide synchronous RAM.
module mem_responder #(
  parameter int AW = 16,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_d,
  input  logic [7:0]    ram_q
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, ACK} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    size_r;
  logic [AW-1:0] base;
  logic [DW-1:0] wdata_r;
  logic [2:0]    cnt;
  logic [2:0]    last_k;
  logic [2:0]    rd_idx;
  logic          last;
  logic [AW-1:0] cur_addr;

  always_comb begin
    last_k = 3'd7;
    case (size_r)
      2'b01:   last_k = 3'd0;
      2'b10:   last_k = 3'd3;
      default: last_k = 3'd7;
    endcase
  end

  assign last     = (cnt == last_k);
  assign rd_idx   = cnt - 3'd1;
  assign cur_addr = base + AW'(cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (size == 2'b00) state_next = ACK;
          else if (we)       state_next = WRITE;
          else               state_next = READ;
        end
      end
      WRITE:   if (last) state_next = ACK;
      READ:    if (last) state_next = DRAIN;
      DRAIN:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM-side outputs depend only on registered state, never on the request pins
  always_comb begin
    ack      = (state == ACK);
    busy     = (state != IDLE);
    ram_we   = (state == WRITE);
    ram_addr = '0;
    ram_d    = 8'h00;
    if (state == WRITE || state == READ) ram_addr = cur_addr;
    if (state == WRITE) ram_d = wdata_r[{cnt, 3'b000} +: 8];
  end

  // ram_q lags the address by one cycle, so byte k lands while presenting k+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_r  <= 2'b00;
      base    <= '0;
      wdata_r <= '0;
      cnt     <= 3'd0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            size_r  <= size;
            base    <= addr;
            wdata_r <= wdata;
            cnt     <= 3'd0;
            if (!we && size != 2'b00) rdata <= '0;
          end
        end
        WRITE: cnt <= cnt + 3'd1;
        READ: begin
          if (cnt != 3'd0) rdata[{rd_idx, 3'b000} +: 8] <= ram_q;
          cnt <= cnt + 3'd1;
        end
        DRAIN: rdata[{last_k, 3'b000} +: 8] <= ram_q;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's sized word accesses: a one-shot 1/4/8-byte read or write request.
- Each request is serviced as a sequence of single-byte accesses to the byte-wide synchronous RAM, little-endian.
- Completion is signalled with a one-cycle ack.
- Sits between the core's address/data buses and the ram block, giving the core a single request/ack interface for all access widths.

Parameters:
- AW, 16: address width in bits, for both the core side and the RAM side.
- DW, 64: data word width in bits. Fixed at 64; the size encoding depends on it.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request valid, level-sensitive, sampled only in IDLE.
- we  input  1  1 = write, 0 = read; latched on accept.
- size  input  2  access width, latched on accept: 01 = 1 byte, 10 = 4 bytes, 11 = 8 bytes, 00 = null access.
- addr  input  AW  byte address of the least-significant byte; latched on accept.
- wdata  input  DW  write data; latched on accept.
- rdata  output  DW  assembled read data.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after accept through the ack cycle.
- ram_addr  output  AW  byte address to the RAM.
- ram_we  output  1  RAM byte write enable.
- ram_d  output  8  RAM write byte.
- ram_q  input  8  RAM read byte; valid one cycle after ram_addr is presented.

Behaviour:
- Reset (asynchronous, rst=1): state goes to IDLE immediately. Outputs take these values:
  - rdata = 0, ack = 0, busy = 0
  - ram_we = 0, ram_addr = 0, ram_d = 0
  - internal latches and byte counter cleared.
- States: IDLE, WRITE, READ, DRAIN, ACK.
- Accept: in IDLE, a rising edge with req=1 latches we, size, addr and wdata. The byte counter is cleared. On a read accept, rdata is cleared to 0.
  - Next state: WRITE if we=1, READ if we=0, ACK if size=00.
- N = 1, 4 or 8 bytes, from size.
- WRITE (N cycles, counter k = 0..N-1):
  - ram_we=1, ram_addr = base+k, ram_d = wdata[8k+7:8k].
  - After k=N-1 the next state is ACK.
- READ (N cycles):
  - ram_we=0, ram_addr = base+k.
  - From k>=1, ram_q is captured into rdata[8(k-1)+7 : 8(k-1)].
  - After k=N-1 the next state is DRAIN.
- DRAIN (1 cycle): captures ram_q into rdata byte N-1; ram_we=0. Next state is ACK.
- ACK (1 cycle): ack=1, busy=1, ram_we=0. Next state is IDLE.
- Latency from the accepting edge:
  - Write: ack is high in cycle N+1 (cycle 2, 5 or 9).
  - Read: ack is high in cycle N+2 (cycle 3, 6 or 10).
  - Null (size=00): ack is high in cycle 1. No RAM access; rdata and RAM contents unchanged.
- Address arithmetic: base+k is computed modulo 2^AW, so accesses wrap from 0xFFFF to 0x0000.
- Read width: for N<8, rdata bytes N..7 are 0 (zero-extended).
- rdata is stable from the ack cycle until the next read is accepted. Writes never alter rdata.
- RAM-side outputs are decoded from registered state only, with no combinational path from req, addr or wdata. Outside WRITE, ram_d = 0. In IDLE, ram_addr = 0.
- Request rules:
  - req is ignored in every state except IDLE, so a request arriving while busy is dropped, not queued.
  - A req still high in the IDLE cycle after ack is a new request. The minimum gap between transactions is one IDLE cycle.
  - The initiator holds addr, we and size stable only until the accepting edge.
- Reset mid-operation: takes effect immediately.
  - ram_we drops asynchronously, ack is never issued for the aborted access, and rdata = 0.
  - Bytes already written stay in RAM.

Test Plan:
- 8-byte write: we=1, size=11, addr=0x0010, wdata=0x0123456789ABCDEF.
  - RAM[0x10..0x17] = EF, CD, AB, 89, 67, 45, 23, 01.
  - ram_we is high exactly 8 cycles; ack pulses once in cycle 9; busy falls after ack.
- Sized reads after the above write:
  - size=10 at 0x0010: rdata = 0x0000000089ABCDEF, ack in cycle 6.
  - size=01 at 0x0013: rdata = 0x0000000000000089, ack in cycle 3.
- Wrap-around write: size=10, addr=0xFFFE, wdata=0x11223344. RAM[0xFFFE]=44, RAM[0xFFFF]=33, RAM[0x0000]=22, RAM[0x0001]=11.
- Busy/back-to-back:
  - A req pulse with we=1 during an 8-byte read is ignored: RAM unchanged, exactly one ack.
  - With req held high across the ack, a second transaction starts in the following IDLE cycle and acks again.
- Reset mid-write: assert rst during byte 2 of an 8-byte write.
  - Immediately: ram_we=0 and busy=0.
  - No ack is issued; bytes 0..1 remain written, bytes 2..7 keep their old values, rdata=0.
- Null access: size=00 gives ack in cycle 1, ram_we never asserted, and rdata equal to its prior value.
